// File: rtl/way_fill_demux.sv
// Assembles an 8-beat cache line fill into a 512-bit line and writes it to one
// way with a single-cycle one-hot enable. Outputs decode from registered state only.
module way_fill_demux #(
    parameter int WAYS      = 8,
    parameter int WAY_BITS  = 3,
    parameter int BEAT_BITS = 64,
    parameter int BEATS     = 8,
    parameter int LINE_BITS = BEAT_BITS * BEATS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fill_start,
    input  logic [WAY_BITS-1:0]  fill_way,
    input  logic                 fill_abort,
    output logic                 fill_ready,
    input  logic                 beat_valid,
    input  logic [BEAT_BITS-1:0] beat_data,
    output logic                 beat_ready,
    output logic [WAYS-1:0]      way_we,
    output logic [LINE_BITS-1:0] way_data,
    output logic                 fill_done,
    output logic                 busy,
    output logic [1:0]           dbg_state_o
);

    localparam int CNT_W = $clog2(BEATS);

    // Handshake: a beat moves on any cycle where beat_valid && beat_ready;
    // fill_start is taken on any cycle where fill_start && fill_ready.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WAY_BITS-1:0]   way_q, way_d;
    logic [LINE_BITS-1:0]  line_q, line_d;

    logic beat_take;
    logic last_beat;

    assign beat_take = (state_q == S_FILL) && beat_valid && !fill_abort;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fill_start) begin
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // Abort wins over a beat presented in the same cycle.
                if (fill_abort) begin
                    state_d = S_IDLE;
                end else if (beat_valid && last_beat) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        fill_ready  = 1'b0;
        beat_ready  = 1'b0;
        fill_done   = 1'b0;
        busy        = 1'b0;
        way_we      = '0;
        dbg_state_o = state_q;
        case (state_q)
            S_IDLE: begin
                fill_ready = 1'b1;
            end
            S_FILL: begin
                beat_ready = 1'b1;
                busy       = 1'b1;
            end
            S_WRITE: begin
                fill_done = 1'b1;
                busy      = 1'b1;
                way_we    = WAYS'(1) << way_q;
            end
            default: begin
                fill_ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        way_d  = way_q;
        line_d = line_q;
        if ((state_q == S_IDLE) && fill_start) begin
            way_d = fill_way;
            cnt_d = '0;
        end
        if (beat_take) begin
            line_d[cnt_q*BEAT_BITS +: BEAT_BITS] = beat_data;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Line bits are never cleared on abort; the next full fill overwrites all of them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            way_q  <= '0;
            line_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            way_q  <= way_d;
            line_q <= line_d;
        end
    end

    assign way_data = line_q;

endmodule

// File: tb/tb_way_fill_demux.sv
// Directed bench for way_fill_demux: fills, stalls, abort, mid-fill meddling,
// asynchronous reset in WRITE and a full way sweep, with a write-enable monitor.
module tb_way_fill_demux;

    logic         clk = 1'b0;
    logic         reset;
    logic         fill_start;
    logic [2:0]   fill_way;
    logic         fill_abort;
    logic         fill_ready;
    logic         beat_valid;
    logic [63:0]  beat_data;
    logic         beat_ready;
    logic [7:0]   way_we;
    logic [511:0] way_data;
    logic         fill_done;
    logic         busy;
    logic [1:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int we_bad  = 0;
    logic [511:0] exp_line;

    way_fill_demux dut (
        .clk         (clk),
        .reset       (reset),
        .fill_start  (fill_start),
        .fill_way    (fill_way),
        .fill_abort  (fill_abort),
        .fill_ready  (fill_ready),
        .beat_valid  (beat_valid),
        .beat_data   (beat_data),
        .beat_ready  (beat_ready),
        .way_we      (way_we),
        .way_data    (way_data),
        .fill_done   (fill_done),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Counts write-enable cycles and flags any that are not a clean one-hot WRITE.
    always @(negedge clk) begin
        if (!reset) begin
            if (way_we != 8'd0) we_cnt++;
            if ((way_we != 8'd0) && (!fill_done || !$onehot(way_we))) we_bad++;
            if ((way_we == 8'd0) && fill_done) we_bad++;
        end
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_val(input logic [63:0] seed, input int k);
        return (64'h1111_1111_1111_1111 * 64'(k)) ^ seed;
    endfunction

    // One complete fill; optional stall after beat stall_after, optional
    // fill_start/fill_way meddling from beat meddle_at onwards.
    task automatic run_fill(input logic [2:0] way, input logic [63:0] seed,
                            input int stall_after, input int stall_len,
                            input int meddle_at, input string tag);
        int cyc;
        int exp_cyc;
        fill_way   = way;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        cyc = 0;
        check({tag, "/busy"}, 512'(busy), 512'(1));
        for (int k = 0; k < 8; k++) begin
            beat_valid = 1'b1;
            beat_data  = beat_val(seed, k);
            exp_line[k*64 +: 64] = beat_data;
            if (k == meddle_at) begin
                fill_start = 1'b1;
                fill_way   = way + 3'd1;
            end
            step();
            cyc++;
            fill_start = 1'b0;
            if (meddle_at >= 0 && k >= meddle_at) fill_way = ~way;
            beat_valid = 1'b0;
            if (k == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    check({tag, "/stall_beat_ready"}, 512'(beat_ready), 512'(1));
                    step();
                    cyc++;
                end
            end
        end
        exp_cyc = (stall_after >= 0) ? 8 + stall_len : 8;
        check({tag, "/latency"}, 512'(cyc), 512'(exp_cyc));
        check({tag, "/way_we"}, 512'(way_we), 512'(8'd1 << way));
        check({tag, "/fill_done"}, 512'(fill_done), 512'(1));
        check({tag, "/way_data"}, way_data, exp_line);
        check({tag, "/ready_in_write"}, 512'({fill_ready, beat_ready}), 512'(0));
        step();
        check({tag, "/we_after"}, 512'(way_we), 512'(0));
        check({tag, "/done_after"}, 512'(fill_done), 512'(0));
        check({tag, "/idle_after"}, 512'({fill_ready, beat_ready, busy}), 512'(3'b100));
    endtask

    initial begin
        reset      = 1'b1;
        fill_start = 1'b0;
        fill_way   = 3'd0;
        fill_abort = 1'b0;
        beat_valid = 1'b0;
        beat_data  = 64'd0;
        exp_line   = '0;
        step();
        check("rst/way_we", 512'(way_we), 512'(0));
        check("rst/way_data", way_data, 512'(0));
        check("rst/flags", 512'({fill_done, busy, beat_ready}), 512'(0));
        check("rst/fill_ready", 512'(fill_ready), 512'(1));
        reset = 1'b0;
        step();

        // A beat offered while idle must be ignored.
        beat_valid = 1'b1;
        beat_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        beat_valid = 1'b0;
        check("idle_beat/state", 512'(dbg_state), 512'(0));
        check("idle_beat/way_data", way_data, 512'(0));

        run_fill(3'd5, 64'd0, -1, 0, -1, "b2b");
        check("b2b/low_beat", 512'(way_data[63:0]), 512'(0));
        check("b2b/high_beat", 512'(way_data[511:448]), 512'(64'h7777_7777_7777_7777));

        run_fill(3'd5, 64'd0, 3, 3, -1, "stall");

        // Abort on beat 4 while a beat is also valid: that beat is discarded.
        fill_way   = 3'd2;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            beat_valid = 1'b1;
            beat_data  = beat_val(64'hA5A5_0000_5A5A_FFFF, k);
            exp_line[k*64 +: 64] = beat_data;
            step();
        end
        beat_valid = 1'b1;
        beat_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        fill_abort = 1'b1;
        step();
        beat_valid = 1'b0;
        fill_abort = 1'b0;
        check("abort/way_we", 512'(way_we), 512'(0));
        check("abort/fill_done", 512'(fill_done), 512'(0));
        check("abort/fill_ready", 512'(fill_ready), 512'(1));
        check("abort/partial_line", way_data, exp_line);
        step();
        check("abort/still_idle", 512'({way_we, dbg_state}), 512'(0));
        run_fill(3'd2, 64'h0123_4567_89AB_CDEF, -1, 0, -1, "post_abort");

        run_fill(3'd6, 64'hCAFE_0000_0000_F00D, -1, 0, 2, "meddle");

        // Asynchronous reset between edges while WRITE is showing.
        fill_way   = 3'd4;
        fill_start = 1'b1;
        step();
        fill_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            beat_valid = 1'b1;
            beat_data  = beat_val(64'h0F0F_0F0F_0F0F_0F0F, k);
            step();
        end
        beat_valid = 1'b0;
        check("rst_write/pre_we", 512'(way_we), 512'(8'h10));
        #2;
        reset = 1'b1;
        #1;
        check("rst_write/way_we", 512'(way_we), 512'(0));
        check("rst_write/way_data", way_data, 512'(0));
        check("rst_write/fill_ready", 512'(fill_ready), 512'(1));
        check("rst_write/fill_done", 512'(fill_done), 512'(0));
        #1;
        reset = 1'b0;
        step();
        check("rst_write/idle", 512'({fill_ready, way_we}), 512'({1'b1, 8'd0}));

        for (int w = 0; w < 8; w++) begin
            run_fill(3'(w), 64'(w) * 64'h0101_0101_0101_0101, -1, 0, -1,
                     $sformatf("sweep%0d", w));
        end

        step();
        check("mon/we_cycles", 512'(we_cnt), 512'(12));
        check("mon/we_bad", 512'(we_bad), 512'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/way_fill_demux.md
Name: way_fill_demux

Overview:
- Write-side counterpart of the cache way read multiplexor.
- Takes a cache line fill arriving from the next memory level as 8 beats of 64 bits and assembles them into a 512-bit line.
- Steers the assembled line to one of 8 ways with a single-cycle one-hot write enable.
- Sits between the L2 miss/fill path and the way data arrays.

Parameters:
- WAYS, 8, number of ways; width of way_we.
- WAY_BITS, 3, width of the way select; equals log2(WAYS).
- BEAT_BITS, 64, width of one fill beat.
- BEATS, 8, beats per line; LINE_BITS = BEAT_BITS*BEATS = 512.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- fill_start  input  1  request to begin a line fill; accepted only while fill_ready=1.
- fill_way  input  3  target way; sampled when fill_start is accepted.
- fill_abort  input  1  cancels a fill in progress; no write is issued.
- fill_ready  output  1  block is idle and can accept fill_start.
- beat_valid  input  1  beat_data is valid.
- beat_data  input  64  one beat of line data; beat 0 first.
- beat_ready  output  1  block accepts a beat this cycle.
- way_we  output  8  one-hot way write enable, asserted for exactly one cycle per completed fill.
- way_data  output  512  assembled line; meaningful when way_we != 0.
- fill_done  output  1  one-cycle pulse, coincident with way_we.
- busy  output  1  high in FILL or WRITE.

Behaviour:
- Reset values (asynchronous): state=IDLE, beat count=0, latched way=0, way_we=8'b0, way_data=0, fill_done=0, busy=0.
- Reset is asynchronous and active-high. After reset deasserts, fill_ready=1 and beat_ready=0.
- All outputs are registered or decoded from the current state only. There is no combinational path from any input to any output.
- IDLE:
  - fill_ready=1, beat_ready=0.
  - fill_start=1 latches fill_way, clears the beat count to 0, and moves to FILL.
  - beat_valid is ignored in IDLE.
- FILL:
  - beat_ready=1, fill_ready=0.
  - A beat transfers on a cycle with beat_valid=1. beat_data is written to line bits [count*64 +: 64] and the count increments.
  - A cycle with beat_valid=0 is a stall: no change.
  - When beat index 7 is accepted, the next state is WRITE.
  - fill_start is ignored in FILL.
- WRITE (exactly one cycle):
  - way_we = 1 << latched way; fill_done=1; way_data = the assembled line.
  - beat_ready=0, fill_ready=0.
  - Next state is IDLE unconditionally.
- Latency: the last beat is accepted on edge N; way_we and fill_done are high from edge N until edge N+1. The earliest possible fill runs start -> write in 10 cycles.
- fill_abort:
  - In FILL, fill_abort has priority over a beat in the same cycle. The beat is discarded and the next state is IDLE. way_we stays 0 and fill_done is not pulsed.
  - In IDLE and WRITE, fill_abort is ignored; a WRITE already in progress completes.
- way_data holds its last value after WRITE until bits are overwritten by the next fill. Consumers sample it only while way_we != 0.
- Bits of a partially filled line are not cleared on abort. A following complete fill overwrites all 512 bits.
- fill_way is sampled only at fill_start acceptance; later changes have no effect on the current fill.
- way_we has at most one bit set at any time. It is never asserted outside WRITE.
- Reset during FILL or WRITE forces IDLE immediately. Any in-flight way_we is cleared and no write completes.

Test Plan:
- Reset, then fill_start with fill_way=5, followed by 8 back-to-back beats with values 0x1111111111111111*k for k=0..7 -> way_we=8'b0010_0000 for one cycle, one cycle after the beat with k=7. way_data[63:0]=0, way_data[511:448]=0x7777777777777777, fill_done pulses once.
- Same fill with beat_valid dropped for 3 cycles after beat 3 -> assembled line is identical; way_we is asserted 3 cycles later than in the back-to-back case; beat_ready stays 1 through the stall.
- fill_way=2; assert fill_abort with beat_valid=1 on beat 4 -> returns to IDLE, way_we stays 0, fill_done never pulses, fill_ready=1 the next cycle. A subsequent full fill to way 2 writes the correct complete line.
- Assert fill_start during FILL with a different fill_way -> request is ignored; the write goes to the originally latched way. Changing fill_way mid-fill has no effect.
- Assert reset asynchronously between clock edges while in WRITE -> way_we=0, way_data=0, fill_ready=1 immediately after the reset edge, with no clock required.
- Sweep fill_way over 0..7 with 8 consecutive fills -> way_we is exactly 1<<way for each fill, and each fill asserts way_we exactly once and only on the WRITE cycle.
